// File: rtl/key_debounce_led.sv
// -----------------------------------------------------------------------------
// key_debounce_led
//
// Debounces KEY_NUM active-low push-buttons. Each key is brought into the
// sys_clk domain through a two-flop synchronizer. A per-key stability counter
// then accepts a new level only after DEB_CYCLES consecutive samples that
// differ from the currently accepted level. Each accepted press (1->0) emits
// a one-cycle pulse and toggles that key's LED.
//
// Ports:
//   sys_clk    in   system clock, all logic on the rising edge
//   sys_rst_n  in   synchronous active-low reset
//   key        in   [KEY_NUM] raw key pins, active-low, asynchronous, bouncing
//   key_value  out  [KEY_NUM] debounced key level, active-low
//   key_press  out  [KEY_NUM] one-cycle pulse per accepted press
//   led        out  [KEY_NUM] LED state, 1 = on, toggles on each press
//
// Handshake: none. Every output is a registered level/pulse with no
// back-pressure; consumers simply sample key_press each cycle.
// -----------------------------------------------------------------------------
module key_debounce_led #(
    parameter int KEY_NUM    = 2,
    parameter int DEB_CYCLES = 4_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_value,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] led
);

    // DEB_CYCLES >= 2, so the width is at least 1 and the terminal count
    // DEB_CYCLES-1 always fits: the counter can never wrap.
    localparam int                CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [KEY_NUM-1:0] s1;
    logic [KEY_NUM-1:0] s2;

    // Synchronizer resets to "released" so reset never looks like a press.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic             stable;
        logic             press_q;
        logic             led_q;
        logic             differ;
        logic             accept;

        assign differ = (s2[i] != stable);
        // The current sample is the DEB_CYCLES-th consecutive differing one.
        assign accept = differ && (cnt == CNT_MAX);

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                cnt     <= '0;
                stable  <= 1'b1;
                press_q <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                // Any sample equal to the accepted level restarts the count,
                // which is what rejects bounce and short glitches.
                if (!differ || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                if (accept) begin
                    stable <= s2[i];
                end

                // accept implies s2 != stable, so s2 == 0 means a 1->0 change.
                press_q <= accept && !s2[i];

                if (press_q) begin
                    led_q <= ~led_q;
                end
            end
        end

        assign key_value[i] = stable;
        assign key_press[i] = press_q;
        assign led[i]       = led_q;
    end

endmodule

// File: tb/tb_key_debounce_led.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_led
//
// Drives key_debounce_led with directed scenarios followed by randomized key
// patterns and resets. A reference model tracks the history of sampled pin
// values and accepts a new level when the last DEB synchronized samples all
// differ from the accepted level; every cycle the DUT outputs are compared
// against it, alongside explicit latency and pulse-count checks.
// -----------------------------------------------------------------------------
module tb_key_debounce_led;

    localparam int KEY_NUM = 2;
    localparam int DEB     = 16;
    localparam int BUDGET  = 60;

    // ---------------- clock / reset ----------------
    logic               sys_clk   = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [KEY_NUM-1:0] key       = '1;
    logic [KEY_NUM-1:0] key_value;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] led;

    always #5 sys_clk = ~sys_clk;

    key_debounce_led #(
        .KEY_NUM   (KEY_NUM),
        .DEB_CYCLES(DEB)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key      (key),
        .key_value(key_value),
        .key_press(key_press),
        .led      (led)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    int press_cnt [KEY_NUM];

    // Reference model: m_hist[0] is the most recent pin sample, m_hist[1]
    // is what the second synchronizer flop currently holds, and so on.
    logic [KEY_NUM-1:0] m_hist [0:DEB];
    logic [KEY_NUM-1:0] m_value;
    logic [KEY_NUM-1:0] m_press;
    logic [KEY_NUM-1:0] m_led;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= DEB; j++) m_hist[j] = '1;
        m_value = '1;
        m_press = '0;
        m_led   = '0;
    endtask

    task automatic model_edge(input logic rst_n_v, input logic [KEY_NUM-1:0] key_v);
        logic [KEY_NUM-1:0] flip;
        if (!rst_n_v) begin
            model_reset();
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                flip[k] = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (m_hist[j][k] == m_value[k]) flip[k] = 1'b0;
            end
            m_led   = m_led ^ m_press;
            m_press = flip & m_value;   // only a released->pressed change pulses
            m_value = m_value ^ flip;
            for (int j = DEB; j >= 1; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = key_v;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst_v, input logic [KEY_NUM-1:0] key_v);
        sys_rst_n = rst_v;
        key       = key_v;
        @(posedge sys_clk);
        model_edge(rst_v, key_v);
        @(negedge sys_clk);
        check("key_value", key_value, m_value);
        check("key_press", key_press, m_press);
        check("led", led, m_led);
        for (int k = 0; k < KEY_NUM; k++)
            if (key_press[k] === 1'b1) press_cnt[k]++;
    endtask

    task automatic hold(input logic rst_v, input logic [KEY_NUM-1:0] key_v, input int n);
        for (int c = 0; c < n; c++) step(rst_v, key_v);
    endtask

    task automatic clear_cnt();
        for (int k = 0; k < KEY_NUM; k++) press_cnt[k] = 0;
    endtask

    // Counts edges from applying key_v until the selected output bit reaches
    // target; an expired budget reports as a latency mismatch.
    task automatic wait_lat(input string tag, input logic [KEY_NUM-1:0] key_v, input int idx,
                            input logic use_press, input logic target, input int exp_n);
        int   n;
        logic obs;
        n = 0;
        do begin
            step(1'b1, key_v);
            n++;
            obs = use_press ? key_press[idx] : key_value[idx];
        end while (obs !== target && n < BUDGET);
        check(tag, n, exp_n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        clear_cnt();

        // Reset behaviour, including keys pressed while reset is held.
        hold(1'b0, 2'b11, 5);
        hold(1'b0, 2'b00, 3);
        check("rst_value", key_value, 2'b11);
        hold(1'b1, 2'b11, 100);
        check("idle_press_cnt", press_cnt[0] + press_cnt[1], 0);

        // Clean press of key0 held for 40 cycles.
        clear_cnt();
        wait_lat("press0_lat", 2'b10, 0, 1'b0, 1'b0, 18);
        check("press0_pulse", key_press, 2'b01);
        step(1'b1, 2'b10);
        check("press0_led", led, 2'b01);
        hold(1'b1, 2'b10, 21);
        check("press0_cnt", press_cnt[0], 1);
        check("press0_cnt1", press_cnt[1], 0);

        // Release: no pulse, level returns after the same latency.
        clear_cnt();
        wait_lat("release0_lat", 2'b11, 0, 1'b0, 1'b1, 18);
        hold(1'b1, 2'b11, 20);
        check("release0_cnt", press_cnt[0], 0);

        // A 15-cycle glitch is one sample short of acceptance.
        hold(1'b1, 2'b10, 15);
        hold(1'b1, 2'b11, 30);
        check("glitch_cnt", press_cnt[0], 0);
        check("glitch_value", key_value, 2'b11);

        // Bouncing second press of key0.
        clear_cnt();
        for (int b = 0; b < 5; b++) begin
            hold(1'b1, 2'b10, 3);
            hold(1'b1, 2'b11, 3);
        end
        wait_lat("bounce_lat", 2'b10, 0, 1'b0, 1'b0, 18);
        hold(1'b1, 2'b10, 20);
        check("bounce_cnt", press_cnt[0], 1);
        check("bounce_led", led, 2'b00);
        hold(1'b1, 2'b11, 40);

        // Simultaneous press of both keys.
        wait_lat("both_lat", 2'b00, 0, 1'b1, 1'b1, 18);
        check("both_pulse", key_press, 2'b11);
        step(1'b1, 2'b00);
        check("both_led", led, 2'b11);
        hold(1'b1, 2'b11, 40);

        // Reset in the middle of a key1 debounce count.
        hold(1'b1, 2'b01, 8);
        hold(1'b0, 2'b01, 2);
        check("midrst_led", led, 2'b00);
        wait_lat("midrst_press1_lat", 2'b01, 1, 1'b1, 1'b1, 18);
        hold(1'b1, 2'b11, 40);

        // Randomized key patterns with occasional resets.
        for (int s = 0; s < 150; s++) begin
            logic [KEY_NUM-1:0] kv;
            kv = KEY_NUM'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                hold(1'b0, kv, $urandom_range(1, 3));
            else
                hold(1'b1, kv, $urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_debounce_led.md
# key_debounce_led

Input-side counterpart to the LED driver blocks: samples the board push-buttons and debounces each one with a per-key stability counter. It emits a clean level and a single-cycle press pulse per key, and toggles one LED per key on every debounced press. It sits between the raw key pins and any logic that needs press events, and directly drives the board LEDs.

## Interface
- `KEY_NUM`, 2, number of keys, and also the number of LEDs (1..8)
- `DEB_CYCLES`, 4_000_000, consecutive stable `sys_clk` cycles required to accept a new key level (20 ms at 200 MHz); minimum 2; reduced to 16 in simulation
- `sys_clk`  input  1  system clock; all logic is on its rising edge
- `sys_rst_n`  input  1  synchronous, active-low reset
- `key`  input  KEY_NUM  raw key pins, active-low (0 = pressed); asynchronous to `sys_clk` and bouncing
- `key_value`  output  KEY_NUM  debounced key level, active-low
- `key_press`  output  KEY_NUM  one-cycle pulse per accepted press (1→0 transition of `key_value`)
- `led`  output  KEY_NUM  LED state, 1 = on; bit i toggles on each `key_press[i]`

## Operation
- All KEY_NUM channels are independent and identical.
- Synchronizer:
  - Two flops per key, `key` → `s1` → `s2`.
  - Both reset to 1 (released).
- Per-key counter `cnt`:
  - Width is `$clog2(DEB_CYCLES)`.
  - Resets to 0.
- Per-key state `stable` drives `key_value`. Each cycle:
  - If `s2 == stable`: `cnt` ← 0.
  - Else if `cnt == DEB_CYCLES-1`: `stable` ← `s2`, and `cnt` ← 0.
  - Else: `cnt` ← `cnt` + 1.
- Bounce: any single cycle with `s2 == stable` restarts the count. A level is accepted only after `DEB_CYCLES` consecutive differing samples.
- `key_press[i]`:
  - Registered 1 on the edge where `stable[i]` goes 1→0.
  - 0 on every other cycle.
  - An accepted release (0→1) produces no pulse.
- `led[i]`:
  - Toggles on the clock edge where `key_press[i]` is 1.
  - Holds otherwise.
- Reset values:
  - `key_value` = all 1.
  - `key_press` = all 0.
  - `led` = all 0.
  - `cnt` = 0.
  - `s1` and `s2` = all 1.
- Reset asserted mid-count or mid-pulse:
  - All state returns to the reset values on the next edge.
  - A pending pulse is dropped.
  - The LED state is lost.
  - After release, a key still held low is accepted as a new press after the full debounce latency.
- Simultaneous presses on several keys produce simultaneous independent pulses and toggles.
- No wrap-around is possible: `cnt` never exceeds `DEB_CYCLES-1`.

## Timing
- Pin to `s2`: 2 edges.
- `s2` to `key_value`: `DEB_CYCLES` edges.
  - Pin change sampled at edge 0 → `key_value` changes after edge `DEB_CYCLES+1`, given a clean input.
- `key_press` is high in the same cycle `key_value` first reads 0. It lasts exactly 1 cycle.
- `led` changes one cycle after `key_press` is high, i.e. it is visible on the following cycle.
- Pulse spacing per key: at least `2*DEB_CYCLES` cycles between two `key_press` pulses, because a release must also be accepted in between.
- Glitch rejection: a low pulse shorter than `DEB_CYCLES` cycles at `s2` produces no change on any output.

## Test plan
All scenarios use `DEB_CYCLES`=16 and `KEY_NUM`=2.
- Reset with `key`=2'b11:
  - `key_value`=2'b11, `key_press`=0 and `led`=2'b00 during reset and for 100 cycles after it.
  - While reset is held, drive `key`=2'b00 → outputs stay at their reset values.
- Clean press of key0, held for 40 cycles:
  - `key_value[0]` goes 0 exactly 18 edges after `key` goes low.
  - `key_press[0]` is high for exactly 1 cycle.
  - `led[0]` goes 1 on the next cycle.
  - `led[1]` stays 0.
- Bouncing press on key0:
  - Stimulus: 5 low/high alternations of 3 cycles each, then held low.
  - `key_value[0]` falls 18 edges after the final falling edge.
  - Exactly 1 `key_press[0]` pulse occurs.
  - The 15-cycle glitch alone produces no pulse.
- Release then second press of key0:
  - Release produces no pulse; `key_value[0]` returns to 1 after 18 edges.
  - The second press produces a second pulse, and `led[0]` returns to 0.
- Simultaneous press of both keys:
  - `key_press`=2'b11 in the same cycle.
  - `led`=2'b11 on the next cycle.
- Reset asserted 8 cycles into a key1 debounce count, held for 2 cycles, with key1 still low:
  - `led` is cleared.
  - After reset is released, `key_press[1]` arrives 18 edges later.
